pipelined_array_multiplier: RTL

Parametrised, pipelined successor to the TinyTapeout combinational array multiplier. It computes WIDTH×WIDTH products in signed or unsigned mode, selected per operand pair. Partial-product rows are split across STAGES register stages, with a valid/ready handshake and full backpressure. The block sits between the tile's operand-capture logic and the result readout mux.

---
 rtl/pipelined_array_multiplier_if.sv | 24 ++
 rtl/pipelined_array_multiplier.sv | 104 ++++++++++
 2 files changed

// File: rtl/pipelined_array_multiplier_if.sv
// Operand/result handshake bundle for the pipelined array multiplier.
// The block drives the slave side; its producer/consumer drive the master side.
interface pipelined_array_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/pipelined_array_multiplier.sv
// WIDTH x WIDTH signed/unsigned array multiplier, ROWS_PER_STAGE partial-product
// rows summed per register stage, valid/ready handshake with full backpressure.
module pipelined_array_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  pipelined_array_multiplier_if.slave bus,
  output logic                       busy
);
  localparam int STAGES = WIDTH / ROWS_PER_STAGE;
  localparam int PW     = 2 * WIDTH;

  if (WIDTH < 4 || WIDTH > 16 || ROWS_PER_STAGE < 1 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_param_check
    $error("pipelined_array_multiplier: WIDTH must be 4..16 and divisible by ROWS_PER_STAGE");
  end

  // One partial-product row; in signed mode the multiplier MSB weighs -2^(WIDTH-1).
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sgn, input int idx);
    logic [PW-1:0]    ext;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    row;
    ext  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_sh = b >> idx;
    row  = b_sh[0] ? (ext << idx) : {PW{1'b0}};
    if (sgn && idx == WIDTH - 1) begin
      row = {PW{1'b0}} - row;
    end
    return row;
  endfunction

  function automatic logic [PW-1:0] stage_sum(input logic [PW-1:0] base, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic sgn,
                                              input int first_row);
    logic [PW-1:0] acc;
    acc = base;
    for (int r = 0; r < ROWS_PER_STAGE; r++) begin
      acc = acc + pp_row(a, b, sgn, first_row + r);
    end
    return acc;
  endfunction

  logic             en;
  logic [STAGES-1:0] valid_vec;

  logic             valid_reg  [STAGES];
  logic [PW-1:0]    sum_reg    [STAGES];
  logic [WIDTH-1:0] a_reg      [STAGES];
  logic [WIDTH-1:0] b_reg      [STAGES];
  logic             signed_reg [STAGES];

  logic             valid_next  [STAGES];
  logic [PW-1:0]    sum_next    [STAGES];
  logic [WIDTH-1:0] a_next      [STAGES];
  logic [WIDTH-1:0] b_next      [STAGES];
  logic             signed_next [STAGES];

  // The whole pipe moves as one; bubbles are only squeezed out by the shift itself.
  assign en              = !valid_reg[STAGES-1] || bus.out_ready;
  assign bus.in_ready    = en && !rst;
  assign bus.out_valid   = valid_reg[STAGES-1];
  assign bus.out_product = sum_reg[STAGES-1];
  assign busy            = |valid_vec;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign valid_next[gi]  = bus.in_valid && bus.in_ready;
      assign a_next[gi]      = bus.in_a;
      assign b_next[gi]      = bus.in_b;
      assign signed_next[gi] = bus.in_signed;
      assign sum_next[gi]    = stage_sum({PW{1'b0}}, bus.in_a, bus.in_b, bus.in_signed, 0);
    end else begin : g_rest
      assign valid_next[gi]  = valid_reg[gi-1];
      assign a_next[gi]      = a_reg[gi-1];
      assign b_next[gi]      = b_reg[gi-1];
      assign signed_next[gi] = signed_reg[gi-1];
      assign sum_next[gi]    = stage_sum(sum_reg[gi-1], a_reg[gi-1], b_reg[gi-1],
                                         signed_reg[gi-1], gi * ROWS_PER_STAGE);
    end
    assign valid_vec[gi] = valid_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s]  <= 1'b0;
        sum_reg[s]    <= '0;
        a_reg[s]      <= '0;
        b_reg[s]      <= '0;
        signed_reg[s] <= 1'b0;
      end
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s]  <= valid_next[s];
        sum_reg[s]    <= sum_next[s];
        a_reg[s]      <= a_next[s];
        b_reg[s]      <= b_next[s];
        signed_reg[s] <= signed_next[s];
      end
    end
  end
endmodule
